inst_rom_resp: RTL and testbench

Instruction-memory responder that sits on the far side of the core's fetch interface. It accepts rom_addr_i / rom_en_i from the core and returns a registered 32-bit instruction. A configurable wait-state sequencer and a boot-loader write port make the block usable both in simulation and as the on-chip instruction store.

---
 rtl/rom_pkg.sv | 22 ++
 rtl/inst_mem_array.sv | 30 +++
 rtl/inst_rom_resp.sv | 129 ++++++++++++
 tb/tb_inst_rom_resp.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared definitions for the instruction ROM responder: bus widths, the
// default NOP encoding, FSM state encoding and the word-index width helper.
package rom_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rom_state_t;

    // Number of word-index bits needed to address 'depth' words.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage : rom_pkg

// File: rtl/inst_mem_array.sv
// Single-clock word array with one synchronous write port and one
// synchronous read port. Reads return the contents from before a write to
// the same word on the same edge (read-first).
module inst_mem_array
    import rom_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [idx_w(DEPTH_WORDS)-1:0] waddr,
    input  logic [INST_W-1:0]            wdata,
    input  logic                         re,
    input  logic [idx_w(DEPTH_WORDS)-1:0] raddr,
    output logic [INST_W-1:0]            rdata
);

    logic [INST_W-1:0] mem [DEPTH_WORDS];

    // Write and registered read on the same edge.
    // NOTE: no reset here on purpose -- a reset on a memory array prevents it
    // from mapping onto block RAM, and contents must survive rst_n anyway.
    // Non-blocking assignments make the read sample the pre-write value,
    // which is exactly the read-first behaviour wanted on a collision.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule : inst_mem_array

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder on the far side of the core fetch port.
// Accepts a fetch, optionally inserts WAIT_CYCLES wait states, then returns
// one registered instruction (or NOP with addr_err_o on a bad address).
// A boot-loader port writes words into the array at any time.
module inst_rom_resp
    import rom_pkg::*;
#(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [INST_W-1:0] NOP_INST    = NOP_INST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rom_addr_i,
    input  logic              rom_en_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              busy_o,
    output logic              addr_err_o,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [INST_W-1:0] ld_data_i
);

    localparam int IW = idx_w(DEPTH_WORDS);

    rom_state_t        state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [IW-1:0]     req_idx, cap_idx, rd_idx, ld_idx;
    logic              req_err, cap_err, rd_err;
    logic              accept, rd_en, ld_ok, out_nop;
    logic [INST_W-1:0] rd_data;

    // Address decode: bits above the index field or in the byte lane are errors.
    assign req_idx = rom_addr_i[IW+1:2];
    assign req_err = (|rom_addr_i[ADDR_W-1:IW+2]) | (|rom_addr_i[1:0]);
    assign ld_idx  = ld_addr_i[IW+1:2];
    assign ld_ok   = ld_we_i & ~(|ld_addr_i[ADDR_W-1:IW+2]) & ~(|ld_addr_i[1:0]);

    // A request is taken whenever the block is not counting wait states.
    assign accept = rom_en_i && (state != ST_WAIT);

    // Next-state, counter and read-issue logic.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_en   = 1'b0;
        rd_idx  = req_idx;
        rd_err  = req_err;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    state_n = ST_RESP;
                    cnt_n   = 4'd0;
                    rd_en   = 1'b1;
                    rd_idx  = cap_idx;
                    rd_err  = cap_err;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                if (rom_en_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = ST_RESP;
                        rd_en   = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = 4'(WAIT_CYCLES);
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    // FSM state and wait counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Capture the request so the core's address is not needed during WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_idx <= '0;
            cap_err <= 1'b0;
        end else if (accept) begin
            cap_idx <= req_idx;
            cap_err <= req_err;
        end
    end

    // Select NOP on the output after reset and for errored responses; holds
    // between responses so a stalled core keeps its last instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_nop <= 1'b1;
        end else if (rd_en) begin
            out_nop <= rd_err;
        end
    end

    inst_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk   (clk),
        .we    (ld_ok),
        .waddr (ld_idx),
        .wdata (ld_data_i),
        .re    (rd_en),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    assign inst_o       = out_nop ? NOP_INST : rd_data;
    assign inst_valid_o = (state == ST_RESP);
    assign addr_err_o   = (state == ST_RESP) && out_nop;
    assign busy_o       = (state == ST_WAIT);

endmodule : inst_rom_resp

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: a zero-wait instance driven from a
// vector table, and a three-wait instance for the multi-cycle sequences.
module tb_inst_rom_resp;
    import rom_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, ld_addr, ld_data;
    logic        en0, en3, ld_we;
    logic [31:0] inst0, inst3;
    logic        v0, v3, b0, b3, e0, e3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_rom_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .NOP_INST(NOP)) dut0 (
        .clk(clk), .rst_n(rst_n), .rom_addr_i(addr), .rom_en_i(en0),
        .inst_o(inst0), .inst_valid_o(v0), .busy_o(b0), .addr_err_o(e0),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    inst_rom_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3), .NOP_INST(NOP)) dut3 (
        .clk(clk), .rst_n(rst_n), .rom_addr_i(addr), .rom_en_i(en3),
        .inst_o(inst3), .inst_valid_o(v3), .busy_o(b3), .addr_err_o(e3),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic        we;
        logic [31:0] ladr;
        logic [31:0] ldat;
        logic        ev;
        logic [31:0] ei;
        logic        ee;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    // Fire one fetch on the three-wait instance and check the full response.
    task automatic fetch3(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; en3 = 1'b1;
        @(posedge clk); #1;
        en3 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("%s busy c%0d", tag, c), 32'(b3), 32'd1);
            check($sformatf("%s valid c%0d", tag, c), 32'(v3), 32'd0);
            @(posedge clk); #1;
        end
        check({tag, " valid c4"}, 32'(v3), 32'd1);
        check({tag, " inst c4"}, inst3, exp);
        check({tag, " busy c4"}, 32'(b3), 32'd0);
        @(posedge clk); #1;
        check({tag, " valid c5"}, 32'(v3), 32'd0);
        check({tag, " hold c5"}, inst3, exp);
    endtask

    initial begin
        bit seen_valid;

        //          en  addr          we  ladr          ldat          ev  ei            ee
        tbl[0]  = '{0, 32'h0,        1, 32'h0,        32'h00500093, 0, NOP,          0};
        tbl[1]  = '{0, 32'h0,        1, 32'h4,        32'h00100113, 0, NOP,          0};
        tbl[2]  = '{0, 32'h0,        1, 32'h8,        32'h002081B3, 0, NOP,          0};
        tbl[3]  = '{0, 32'h0,        1, 32'hC,        32'h0000006F, 0, NOP,          0};
        tbl[4]  = '{1, 32'h0,        0, 32'h0,        32'h0,        1, 32'h00500093, 0};
        tbl[5]  = '{1, 32'h4,        0, 32'h0,        32'h0,        1, 32'h00100113, 0};
        tbl[6]  = '{1, 32'h8,        0, 32'h0,        32'h0,        1, 32'h002081B3, 0};
        tbl[7]  = '{1, 32'hC,        0, 32'h0,        32'h0,        1, 32'h0000006F, 0};
        tbl[8]  = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0000006F, 0};
        tbl[9]  = '{1, 32'h4,        0, 32'h0,        32'h0,        1, 32'h00100113, 0};
        tbl[10] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00100113, 0};
        tbl[11] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00100113, 0};
        tbl[12] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00100113, 0};
        tbl[13] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00100113, 0};
        tbl[14] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h00100113, 0};
        tbl[15] = '{1, 32'h1000,     0, 32'h0,        32'h0,        1, NOP,          1};
        tbl[16] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, NOP,          0};
        tbl[17] = '{1, 32'h2,        0, 32'h0,        32'h0,        1, NOP,          1};
        tbl[18] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, NOP,          0};
        tbl[19] = '{0, 32'h0,        1, 32'h1004,     32'hBAD0BAD0, 0, NOP,          0};
        tbl[20] = '{1, 32'h4,        0, 32'h0,        32'h0,        1, 32'h00100113, 0};
        tbl[21] = '{1, 32'h4,        1, 32'h6,        32'h11111111, 1, 32'h00100113, 0};
        tbl[22] = '{1, 32'h4,        0, 32'h0,        32'h0,        1, 32'h00100113, 0};
        tbl[23] = '{1, 32'h0,        1, 32'h0,        32'hDEADBEEF, 1, 32'h00500093, 0};
        tbl[24] = '{1, 32'h0,        0, 32'h0,        32'h0,        1, 32'hDEADBEEF, 0};
        tbl[25] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'hDEADBEEF, 0};

        rst_n = 1'b0; en0 = 1'b0; en3 = 1'b0; addr = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset inst0", inst0, NOP);
        check("reset valid0", 32'(v0), 32'd0);
        check("reset busy3", 32'(b3), 32'd0);
        check("reset err0", 32'(e0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait instance: load, streaming fetch, stall, errors, collision.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            en0 = tbl[i].en; addr = tbl[i].addr;
            ld_we = tbl[i].we; ld_addr = tbl[i].ladr; ld_data = tbl[i].ldat;
            @(posedge clk); #1;
            check($sformatf("row%0d valid", i), 32'(v0), 32'(tbl[i].ev));
            check($sformatf("row%0d inst", i), inst0, tbl[i].ei);
            check($sformatf("row%0d err", i), 32'(e0), 32'(tbl[i].ee));
            check($sformatf("row%0d busy", i), 32'(b0), 32'd0);
        end
        @(negedge clk);
        en0 = 1'b0; ld_we = 1'b0;

        // Three wait states: busy for three cycles, response on the fourth.
        fetch3("wait3 addr8", 32'h8, 32'h002081B3);

        // Reset in the middle of WAIT abandons the request.
        @(negedge clk);
        addr = 32'h4; en3 = 1'b1;
        @(posedge clk); #1;
        en3 = 1'b0;
        @(posedge clk); #1;
        check("pre-reset busy3", 32'(b3), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset busy3", 32'(b3), 32'd0);
        check("async reset valid3", 32'(v3), 32'd0);
        check("async reset inst3", inst3, NOP);
        check("async reset err3", 32'(e3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (v3 || b3) seen_valid = 1'b1;
        end
        check("no response after reset", 32'(seen_valid), 32'd0);
        check("inst3 after reset", inst3, NOP);

        // Memory contents survive reset.
        fetch3("post-reset addr4", 32'h4, 32'h00100113);
        fetch3("post-reset addr0", 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        addr = 32'hC; en0 = 1'b1;
        @(posedge clk); #1;
        en0 = 1'b0;
        check("post-reset dut0 valid", 32'(v0), 32'd1);
        check("post-reset dut0 inst", inst0, 32'h0000006F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_inst_rom_resp
